// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_pkg
//  Purpose  : Shared definitions for the reg_file_sb register file:
//             - init/run FSM state encoding
//             - default widths
//             - generic sign-extension helper used by the immediate unit
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rf_pkg;

  // Init sequencer states.
  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Default widths.
  localparam int unsigned RF_DATA_W      = 8;
  localparam int unsigned RF_NUM_REGS    = 8;
  localparam int unsigned RF_ADDR_W      = 3;
  localparam int unsigned RF_IMM_W       = 6;
  localparam int unsigned RF_IMM_SHORT_W = 3;

  // Sign-extend the low `width` bits of val to 64 bits. Bits above the field
  // are replaced by copies of bit width-1, so callers may pass a wider raw
  // value and select a shorter field purely through `width` (1..64).
  function automatic logic [63:0] sign_extend(input logic [63:0]   val,
                                              input int unsigned   width);
    logic [63:0] mask;
    logic [5:0]  sign_bit;
    mask     = ~64'd0 << width;
    sign_bit = 6'(width - 1);
    return val[sign_bit] ? (val | mask) : (val & ~mask);
  endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : rf_scoreboard
//  Purpose  : Per-register busy bits tracking in-flight writes, used by decode
//             to detect RAW hazards.
//  Ports    : Clk, Reset (sync, active-low)
//             Enable          - high once the register file is initialised
//             RegWrite/Write_Reg_Num   - writeback, clears the busy bit
//             Issue_Valid/Issue_Reg_Num - issue, sets the busy bit
//             Read_Reg_Num_A/B -> Busy_A/B lookups
//  Revision : 1.0  initial release
// ============================================================================
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REGS    = RF_NUM_REGS,
  parameter int unsigned ADDR_W      = RF_ADDR_W,
  parameter bit          BYPASS_EN   = 1'b1,
  parameter bit          ZERO_REG_EN = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Write_Reg_Num,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Reg_Num,
  input  logic [ADDR_W-1:0] Read_Reg_Num_A,
  input  logic [ADDR_W-1:0] Read_Reg_Num_B,
  output logic              Busy_A,
  output logic              Busy_B
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear is applied before set so that a same-cycle issue to the register
  // being written back leaves it busy: the newer producer is still pending.
  always_comb begin
    busy_d = busy_q;
    if (Enable) begin
      if (RegWrite)    busy_d[Write_Reg_Num] = 1'b0;
      if (Issue_Valid) busy_d[Issue_Reg_Num] = 1'b1;
    end
    if (ZERO_REG_EN) busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A writeback landing this cycle only resolves the hazard when the read
  // port can actually see it through the bypass.
  logic w_hit_a;
  logic w_hit_b;
  assign w_hit_a = BYPASS_EN && RegWrite && (Write_Reg_Num == Read_Reg_Num_A);
  assign w_hit_b = BYPASS_EN && RegWrite && (Write_Reg_Num == Read_Reg_Num_B);

  assign Busy_A = Enable && busy_q[Read_Reg_Num_A] && !w_hit_a;
  assign Busy_B = Enable && busy_q[Read_Reg_Num_B] && !w_hit_b;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : Multi-read register file with write->read bypass, sequenced
//             reset initialisation (RegMem[i] = i), busy-bit scoreboard and
//             immediate sign-extension unit.
//  Ports    : Clk, Reset (sync, active-low)
//             Read_Reg_Num_A/B -> Read_Data_A/B, Busy_A/B (combinational)
//             RegWrite, Write_Reg_Num, Write_Data  - write port
//             Issue_Valid, Issue_Reg_Num           - scoreboard set
//             Immediate_Raw, ImmSel -> Imm_Data    - sign-extended immediate
//             Init_Done                            - low while initialising
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W      = RF_DATA_W,
  parameter int unsigned NUM_REGS    = RF_NUM_REGS,
  parameter int unsigned ADDR_W      = RF_ADDR_W,
  parameter int unsigned IMM_W       = RF_IMM_W,
  parameter int unsigned IMM_SHORT_W = RF_IMM_SHORT_W,
  parameter bit          BYPASS_EN   = 1'b1,
  parameter bit          ZERO_REG_EN = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Read_Reg_Num_A,
  input  logic [ADDR_W-1:0] Read_Reg_Num_B,
  output logic [DATA_W-1:0] Read_Data_A,
  output logic [DATA_W-1:0] Read_Data_B,
  output logic              Busy_A,
  output logic              Busy_B,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Write_Reg_Num,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Reg_Num,
  input  logic [IMM_W-1:0]  Immediate_Raw,
  input  logic              ImmSel,
  output logic [DATA_W-1:0] Imm_Data,
  output logic              Init_Done
);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] init_idx_q;
  logic              init_done_q;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic w_run;
  logic w_wr_en;

  assign w_run   = (state_q == RF_RUN);
  // Writes to register 0 vanish when it is hard-wired to zero.
  assign w_wr_en = RegWrite && !(ZERO_REG_EN && (Write_Reg_Num == '0));

  // --------------------------------------------------------------------------
  // Init sequencer and array write port. Holding Reset low parks the FSM at
  // index 0; every release replays the full RegMem[i] = i sequence.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= RF_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        RF_INIT: begin
          mem_q[init_idx_q] <= DATA_W'(init_idx_q);
          init_idx_q        <= init_idx_q + ADDR_W'(1);
          if (init_idx_q == ADDR_W'(NUM_REGS - 1)) begin
            state_q     <= RF_RUN;
            init_done_q <= 1'b1;
          end
        end
        RF_RUN: begin
          if (w_wr_en) mem_q[Write_Reg_Num] <= Write_Data;
        end
      endcase
    end
  end

  assign Init_Done = init_done_q;

  // --------------------------------------------------------------------------
  // Read ports. Priority: initialising -> 0, hard-wired zero reg -> 0,
  // same-cycle writeback (bypass) -> Write_Data, else array contents.
  // --------------------------------------------------------------------------
  always_comb begin
    Read_Data_A = mem_q[Read_Reg_Num_A];
    if (!w_run)
      Read_Data_A = '0;
    else if (ZERO_REG_EN && (Read_Reg_Num_A == '0))
      Read_Data_A = '0;
    else if (BYPASS_EN && RegWrite && (Write_Reg_Num == Read_Reg_Num_A))
      Read_Data_A = Write_Data;
  end

  always_comb begin
    Read_Data_B = mem_q[Read_Reg_Num_B];
    if (!w_run)
      Read_Data_B = '0;
    else if (ZERO_REG_EN && (Read_Reg_Num_B == '0))
      Read_Data_B = '0;
    else if (BYPASS_EN && RegWrite && (Write_Reg_Num == Read_Reg_Num_B))
      Read_Data_B = Write_Data;
  end

  // --------------------------------------------------------------------------
  // Scoreboard. Init_Done gates it so that issues/writebacks during the
  // initialisation sequence are ignored and Busy_A/B read 0.
  // --------------------------------------------------------------------------
  rf_scoreboard #(
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .BYPASS_EN   (BYPASS_EN),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_scoreboard (
    .Clk            (Clk),
    .Reset          (Reset),
    .Enable         (init_done_q),
    .RegWrite       (RegWrite),
    .Write_Reg_Num  (Write_Reg_Num),
    .Issue_Valid    (Issue_Valid),
    .Issue_Reg_Num  (Issue_Reg_Num),
    .Read_Reg_Num_A (Read_Reg_Num_A),
    .Read_Reg_Num_B (Read_Reg_Num_B),
    .Busy_A         (Busy_A),
    .Busy_B         (Busy_B)
  );

  // --------------------------------------------------------------------------
  // Immediate unit: the full raw field is handed over; the selected width
  // decides which bit acts as the sign and everything above it is replaced.
  // --------------------------------------------------------------------------
  logic [63:0] w_imm_ext;
  assign w_imm_ext = sign_extend(64'(Immediate_Raw), ImmSel ? IMM_W : IMM_SHORT_W);
  assign Imm_Data  = w_imm_ext[DATA_W-1:0];

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Purpose  : Self-checking bench for reg_file_sb. Three instances share one
//             stimulus stream: default (bypass on), bypass off, and register 0
//             hard-wired to zero. A behavioural model tracks the array and the
//             set of outstanding writes per instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_sb;

  localparam int DW   = 8;
  localparam int NR   = 8;
  localparam int AW   = 3;
  localparam int IW   = 6;
  localparam int ISW  = 3;
  localparam int NCFG = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [AW-1:0] Read_Reg_Num_A = '0;
  logic [AW-1:0] Read_Reg_Num_B = '0;
  logic          RegWrite = 1'b0;
  logic [AW-1:0] Write_Reg_Num = '0;
  logic [DW-1:0] Write_Data = '0;
  logic          Issue_Valid = 1'b0;
  logic [AW-1:0] Issue_Reg_Num = '0;
  logic [IW-1:0] Immediate_Raw = '0;
  logic          ImmSel = 1'b0;

  logic [DW-1:0] rd_a  [NCFG];
  logic [DW-1:0] rd_b  [NCFG];
  logic [DW-1:0] imm   [NCFG];
  logic          bsy_a [NCFG];
  logic          bsy_b [NCFG];
  logic          done  [NCFG];

  bit cfg_byp  [NCFG] = '{1'b1, 1'b0, 1'b1};
  bit cfg_zero [NCFG] = '{1'b0, 1'b0, 1'b1};

  int  n_checks = 0;
  int  n_err    = 0;
  bit  check_en = 1'b0;

  always #5 Clk = ~Clk;

  reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .IMM_W(IW), .IMM_SHORT_W(ISW),
                .BYPASS_EN(1'b1), .ZERO_REG_EN(1'b0)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .Read_Reg_Num_A(Read_Reg_Num_A), .Read_Reg_Num_B(Read_Reg_Num_B),
    .Read_Data_A(rd_a[0]), .Read_Data_B(rd_b[0]), .Busy_A(bsy_a[0]), .Busy_B(bsy_b[0]),
    .RegWrite(RegWrite), .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data),
    .Issue_Valid(Issue_Valid), .Issue_Reg_Num(Issue_Reg_Num),
    .Immediate_Raw(Immediate_Raw), .ImmSel(ImmSel), .Imm_Data(imm[0]), .Init_Done(done[0]));

  reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .IMM_W(IW), .IMM_SHORT_W(ISW),
                .BYPASS_EN(1'b0), .ZERO_REG_EN(1'b0)) u_nobyp (
    .Clk(Clk), .Reset(Reset),
    .Read_Reg_Num_A(Read_Reg_Num_A), .Read_Reg_Num_B(Read_Reg_Num_B),
    .Read_Data_A(rd_a[1]), .Read_Data_B(rd_b[1]), .Busy_A(bsy_a[1]), .Busy_B(bsy_b[1]),
    .RegWrite(RegWrite), .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data),
    .Issue_Valid(Issue_Valid), .Issue_Reg_Num(Issue_Reg_Num),
    .Immediate_Raw(Immediate_Raw), .ImmSel(ImmSel), .Imm_Data(imm[1]), .Init_Done(done[1]));

  reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .IMM_W(IW), .IMM_SHORT_W(ISW),
                .BYPASS_EN(1'b1), .ZERO_REG_EN(1'b1)) u_zero (
    .Clk(Clk), .Reset(Reset),
    .Read_Reg_Num_A(Read_Reg_Num_A), .Read_Reg_Num_B(Read_Reg_Num_B),
    .Read_Data_A(rd_a[2]), .Read_Data_B(rd_b[2]), .Busy_A(bsy_a[2]), .Busy_B(bsy_b[2]),
    .RegWrite(RegWrite), .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data),
    .Issue_Valid(Issue_Valid), .Issue_Reg_Num(Issue_Reg_Num),
    .Immediate_Raw(Immediate_Raw), .ImmSel(ImmSel), .Imm_Data(imm[2]), .Init_Done(done[2]));

  // --------------------------------------------------------------------------
  // Reference model: m_cnt counts initialisation edges since reset release
  // (NR means the file is usable); arrays hold contents and outstanding writes.
  // --------------------------------------------------------------------------
  int            m_cnt = 0;
  logic [DW-1:0] m_mem  [NCFG][NR];
  bit            m_busy [NCFG][NR];

  always @(posedge Clk) begin
    if (!Reset) begin
      m_cnt <= 0;
      for (int c = 0; c < NCFG; c++)
        for (int r = 0; r < NR; r++) m_busy[c][r] <= 1'b0;
    end else if (m_cnt < NR) begin
      for (int c = 0; c < NCFG; c++) m_mem[c][m_cnt] <= DW'(m_cnt);
      m_cnt <= m_cnt + 1;
    end else begin
      for (int c = 0; c < NCFG; c++) begin
        if (RegWrite && !(cfg_zero[c] && Write_Reg_Num == 0))
          m_mem[c][Write_Reg_Num] <= Write_Data;
        // Later assignment wins: an issue overrides a same-register writeback.
        if (RegWrite) m_busy[c][Write_Reg_Num] <= 1'b0;
        if (Issue_Valid && !(cfg_zero[c] && Issue_Reg_Num == 0))
          m_busy[c][Issue_Reg_Num] <= 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input int c, input logic [AW-1:0] r);
    if (m_cnt < NR) return '0;
    if (cfg_zero[c] && r == 0) return '0;
    if (cfg_byp[c] && RegWrite && Write_Reg_Num == r) return Write_Data;
    return m_mem[c][r];
  endfunction

  function automatic logic exp_busy(input int c, input logic [AW-1:0] r);
    if (m_cnt < NR) return 1'b0;
    return m_busy[c][r] && !(cfg_byp[c] && RegWrite && Write_Reg_Num == r);
  endfunction

  // Two's-complement interpretation of the selected field, then wrap to DW.
  function automatic logic [DW-1:0] exp_imm(input logic [IW-1:0] raw, input logic sel);
    int w;
    int v;
    w = sel ? IW : ISW;
    v = int'(raw) % (1 << w);
    if (v >= (1 << (w - 1))) v = v - (1 << w);
    return DW'(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison of every output of every instance.
  always @(negedge Clk) begin
    if (check_en) begin
      for (int c = 0; c < NCFG; c++) begin
        chk($sformatf("cfg%0d Read_Data_A", c), 32'(rd_a[c]), 32'(exp_rd(c, Read_Reg_Num_A)));
        chk($sformatf("cfg%0d Read_Data_B", c), 32'(rd_b[c]), 32'(exp_rd(c, Read_Reg_Num_B)));
        chk($sformatf("cfg%0d Busy_A", c), 32'(bsy_a[c]), 32'(exp_busy(c, Read_Reg_Num_A)));
        chk($sformatf("cfg%0d Busy_B", c), 32'(bsy_b[c]), 32'(exp_busy(c, Read_Reg_Num_B)));
        chk($sformatf("cfg%0d Imm_Data", c), 32'(imm[c]), 32'(exp_imm(Immediate_Raw, ImmSel)));
        chk($sformatf("cfg%0d Init_Done", c), 32'(done[c]), 32'(m_cnt == NR));
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // ---- Reset held low for two edges, then init sequence ----
    step();
    check_en = 1'b1;
    step();
    Reset = 1'b1;
    Read_Reg_Num_A = 3'd5;
    RegWrite = 1'b1; Write_Reg_Num = 3'd5; Write_Data = 8'hEE;   // must be ignored
    Issue_Valid = 1'b1; Issue_Reg_Num = 3'd5;                    // must be ignored
    for (int i = 0; i < NR; i++) begin
      chk("t1 Init_Done low", 32'(done[0]), 32'd0);
      step();
    end
    RegWrite = 1'b0; Issue_Valid = 1'b0;
    #1;
    chk("t1 Init_Done high", 32'(done[0]), 32'd1);
    chk("t1 reg5 init value", 32'(rd_a[0]), 32'h05);
    chk("t1 reg5 not busy", 32'(bsy_a[0]), 32'd0);

    // ---- Bypass vs. no bypass ----
    RegWrite = 1'b1; Write_Reg_Num = 3'd3; Write_Data = 8'hA5; Read_Reg_Num_A = 3'd3;
    #1;
    chk("t2 bypass same cycle", 32'(rd_a[0]), 32'hA5);
    chk("t2 nobypass old value", 32'(rd_a[1]), 32'h03);
    step();
    RegWrite = 1'b0;
    #1;
    chk("t2 nobypass next cycle", 32'(rd_a[1]), 32'hA5);

    // ---- Scoreboard set / set-wins / clear ----
    Read_Reg_Num_B = 3'd2; Issue_Valid = 1'b1; Issue_Reg_Num = 3'd2;
    step();
    Issue_Valid = 1'b0;
    #1;
    chk("t3 busy after issue", 32'(bsy_b[0]), 32'd1);
    RegWrite = 1'b1; Write_Reg_Num = 3'd2; Write_Data = 8'h22;
    Issue_Valid = 1'b1; Issue_Reg_Num = 3'd2;
    #1;
    chk("t3 nobypass hazard held", 32'(bsy_b[1]), 32'd1);
    step();
    RegWrite = 1'b0; Issue_Valid = 1'b0;
    #1;
    chk("t3 set wins over clear", 32'(bsy_b[0]), 32'd1);
    RegWrite = 1'b1; Write_Reg_Num = 3'd2; Write_Data = 8'h33;
    step();
    RegWrite = 1'b0;
    #1;
    chk("t3 cleared by writeback", 32'(bsy_b[0]), 32'd0);
    chk("t3 written value", 32'(rd_b[0]), 32'h33);

    // ---- Immediate unit ----
    Immediate_Raw = 6'b101101; ImmSel = 1'b1;
    #1 chk("t4 imm full", 32'(imm[0]), 32'hED);
    ImmSel = 1'b0;
    #1 chk("t4 imm short neg", 32'(imm[0]), 32'hFD);
    Immediate_Raw = 6'b000011;
    #1 chk("t4 imm short pos", 32'(imm[0]), 32'h03);

    // ---- Reset mid-RUN and mid-INIT ----
    RegWrite = 1'b1; Write_Reg_Num = 3'd1; Write_Data = 8'h77;
    Issue_Valid = 1'b1; Issue_Reg_Num = 3'd6;
    step();
    RegWrite = 1'b0; Issue_Valid = 1'b0; Read_Reg_Num_A = 3'd1;
    #1 chk("t5 reg1 written", 32'(rd_a[0]), 32'h77);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    repeat (4) step();
    chk("t5 still initialising", 32'(done[0]), 32'd0);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    for (int k = 0; k < 20 && done[0] !== 1'b1; k++) step();
    chk("t5 init completes", 32'(done[0]), 32'd1);
    for (int i = 0; i < NR; i++) begin
      Read_Reg_Num_A = AW'(i);
      #1;
      chk($sformatf("t5 reg%0d reinit", i), 32'(rd_a[0]), i);
      chk($sformatf("t5 reg%0d busy clear", i), 32'(bsy_a[0]), 32'd0);
    end

    // ---- Hard-wired zero register ----
    Read_Reg_Num_A = 3'd0;
    RegWrite = 1'b1; Write_Reg_Num = 3'd0; Write_Data = 8'hFF;
    #1;
    chk("t6 zero reg bypass blocked", 32'(rd_a[2]), 32'd0);
    chk("t6 normal reg bypass", 32'(rd_a[0]), 32'hFF);
    step();
    RegWrite = 1'b0; Issue_Valid = 1'b1; Issue_Reg_Num = 3'd0;
    #1;
    chk("t6 zero reg after write", 32'(rd_a[2]), 32'd0);
    chk("t6 normal reg after write", 32'(rd_a[0]), 32'hFF);
    step();
    Issue_Valid = 1'b0;
    #1;
    chk("t6 zero reg never busy", 32'(bsy_a[2]), 32'd0);
    chk("t6 normal reg busy", 32'(bsy_a[0]), 32'd1);

    // ---- Randomised traffic, checked every cycle by the compare process ----
    repeat (600) begin
      Reset          = ($urandom_range(0, 79) != 0);
      RegWrite       = 1'($urandom_range(0, 1));
      Write_Reg_Num  = AW'($urandom);
      Write_Data     = DW'($urandom);
      Issue_Valid    = ($urandom_range(0, 4) < 2);
      Issue_Reg_Num  = AW'($urandom);
      Read_Reg_Num_A = AW'($urandom);
      Read_Reg_Num_B = ($urandom_range(0, 3) == 0) ? Write_Reg_Num : AW'($urandom);
      Immediate_Raw  = IW'($urandom);
      ImmSel         = 1'($urandom_range(0, 1));
      step();
    end

    @(negedge Clk);
    check_en = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_reg_file_sb
`default_nettype wire
